// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared LZ77 token format, window geometry and FSM state type
package lz77_pkg;

  localparam int N         = 8;
  localparam int SIZE_CNT  = 3;
  localparam int SIZE_POS  = 5;
  localparam int COUNT_POS = 31;

  localparam logic [N-1:0] LIT_ESCAPE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    LIT,
    COPY
  } lz77_state_t;

  function automatic logic [SIZE_CNT-1:0] token_cnt(input logic [N-1:0] tok);
    return tok[N-1 -: SIZE_CNT];
  endfunction

  function automatic logic [SIZE_POS-1:0] token_pos(input logic [N-1:0] tok);
    return tok[SIZE_POS-1:0];
  endfunction

endpackage

// File: rtl/lz77_token_fifo.sv
// rtl/lz77_token_fifo.sv - synchronous token FIFO with full/empty flags
module lz77_token_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             rdclk,
  input  logic             nreset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A pop on the same edge frees the slot, so a full FIFO can still take a write.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge rdclk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge rdclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lz77_decoder.sv
// rtl/lz77_decoder.sv - LZ77 token stream decoder; LZ77_DECODER_CHECK_EN adds err/tok_cnt
module lz77_decoder
  import lz77_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         rdclk,
  input  logic         nreset,
  input  logic         en,
  input  logic         ready_in,
  input  logic [N-1:0] byte_in,
  output logic         get,
  output logic         ready,
  output logic [N-1:0] byte_out,
  output logic         overflow
`ifdef LZ77_DECODER_CHECK_EN
  ,
  output logic         err,
  output logic [15:0]  tok_cnt
`endif
);

  lz77_state_t state;
  lz77_state_t state_next;

  logic [N-1:0]        window [COUNT_POS];
  logic [SIZE_POS-1:0] fill;
  logic [SIZE_CNT-1:0] rem;
  logic [SIZE_POS-1:0] src_pos;

  logic [N-1:0]        fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                emit;
  logic [N-1:0]        emit_byte;
  logic                load;

  logic [SIZE_CNT-1:0] head_cnt;
  logic [SIZE_POS-1:0] head_pos;

  assign head_cnt = token_cnt(fifo_head);
  assign head_pos = token_pos(fifo_head);
  assign get      = !fifo_full;

  lz77_token_fifo #(
    .WIDTH (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .rdclk  (rdclk),
    .nreset (nreset),
    .push   (ready_in),
    .wdata  (byte_in),
    .pop    (pop),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge rdclk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    emit       = 1'b0;
    emit_byte  = fifo_head;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (en && !fifo_empty) begin
          pop = 1'b1;
          if (fifo_head == LIT_ESCAPE) begin
            state_next = LIT;
          end else if (head_cnt != '0 && head_pos != '0) begin
            load       = 1'b1;
            state_next = COPY;
          end
        end
      end
      LIT: begin
        if (en && !fifo_empty) begin
          pop        = 1'b1;
          emit       = 1'b1;
          emit_byte  = fifo_head;
          state_next = IDLE;
        end
      end
      COPY: begin
        // src_pos stays fixed: each shift moves the next source byte into place.
        if (en) begin
          emit      = 1'b1;
          emit_byte = window[src_pos - 5'd1];
          if (rem == 3'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rdclk or negedge nreset) begin
    if (!nreset) begin
      ready    <= 1'b0;
      byte_out <= '0;
      overflow <= 1'b0;
      fill     <= '0;
      rem      <= '0;
      src_pos  <= '0;
      for (int i = 0; i < COUNT_POS; i++) window[i] <= '0;
    end else begin
      ready <= emit;
      if (emit) begin
        byte_out <= emit_byte;
        for (int i = COUNT_POS - 1; i > 0; i--) window[i] <= window[i-1];
        window[0] <= emit_byte;
        if (fill != 5'(COUNT_POS)) fill <= fill + 5'd1;
      end
      if (load) begin
        rem     <= head_cnt;
        src_pos <= head_pos;
      end else if (emit && state == COPY) begin
        rem <= rem - 3'd1;
      end
      if (ready_in && fifo_full && !pop) overflow <= 1'b1;
    end
  end

`ifdef LZ77_DECODER_CHECK_EN
  logic token_pop;
  logic token_bad;

  assign token_pop = pop && (state == IDLE);
  assign token_bad = (fifo_head != LIT_ESCAPE) &&
                     ((head_cnt != '0 && head_pos == '0) ||
                      (head_cnt == '0) ||
                      (head_pos > fill));

  always_ff @(posedge rdclk or negedge nreset) begin
    if (!nreset) begin
      err     <= 1'b0;
      tok_cnt <= '0;
    end else if (token_pop) begin
      tok_cnt <= tok_cnt + 16'd1;
      if (token_bad) err <= 1'b1;
    end
  end
`endif

endmodule
